// File: rtl/awmc_pkg.sv
// Shared types and defaults for the washing-machine front-panel slice.
package awmc_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RUN        = 2'd1,
        PAUSED     = 2'd2,
        DONE_ALERT = 2'd3
    } panel_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int BUZZ_CYCLES_DEF     = 8;

endpackage

// File: rtl/awmc_panel_input_if.sv
// Panel-side signal bundle between the raw panel and the controller.
interface awmc_panel_input_if;

    logic btn_start_raw;
    logic btn_pause_raw;
    logic lid_raw;
    logic done;
    logic start;
    logic pause;
    logic lid;
    logic buzzer;
    logic run_led;

    modport master (
        output btn_start_raw, btn_pause_raw, lid_raw, done,
        input  start, pause, lid, buzzer, run_led
    );

    modport slave (
        input  btn_start_raw, btn_pause_raw, lid_raw, done,
        output start, pause, lid, buzzer, run_led
    );

endinterface

// File: rtl/awmc_debounce.sv
// Synchroniser, counting debouncer and rising-edge pulse for one input.
module awmc_debounce
    import awmc_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   synced;

    assign synced = sync[SYNC_STAGES-1];

    // Counter clears at the flip point, so it never exceeds CNT_MAX.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
            rise <= 1'b0;
            if (synced == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt   <= '0;
                level <= synced;
                rise  <= synced;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/awmc_panel_input.sv
// Front-panel conditioning: debounced buttons/lid to controller commands.
module awmc_panel_input
    import awmc_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int BUZZ_CYCLES     = BUZZ_CYCLES_DEF
) (
    input logic               clk,
    input logic               reset,
    awmc_panel_input_if.slave bus
);

    localparam int BW = $clog2(BUZZ_CYCLES + 1);
    localparam logic [BW-1:0] BUZZ_LOAD = BW'(BUZZ_CYCLES);
    localparam logic [BW-1:0] BUZZ_LAST = BW'(1);

    panel_state_t  state;
    logic [BW-1:0] buzz_cnt;
    logic          start_ev;
    logic          pause_ev;
    logic          lid_level;
    logic          unused_start_level;
    logic          unused_pause_level;
    logic          unused_lid_rise;

    awmc_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_start (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.btn_start_raw),
        .level (unused_start_level),
        .rise  (start_ev)
    );

    awmc_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_pause (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.btn_pause_raw),
        .level (unused_pause_level),
        .rise  (pause_ev)
    );

    awmc_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_lid (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.lid_raw),
        .level (lid_level),
        .rise  (unused_lid_rise)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            buzz_cnt    <= '0;
            bus.start   <= 1'b0;
            bus.pause   <= 1'b0;
            bus.lid     <= 1'b0;
            bus.buzzer  <= 1'b0;
            bus.run_led <= 1'b0;
        end else begin
            bus.lid   <= lid_level;
            bus.start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_ev && lid_level) begin
                        state       <= RUN;
                        bus.start   <= 1'b1;
                        bus.run_led <= 1'b1;
                    end
                end
                RUN: begin
                    // A finishing cycle takes priority over a pause request.
                    if (bus.done) begin
                        state       <= DONE_ALERT;
                        buzz_cnt    <= BUZZ_LOAD;
                        bus.buzzer  <= 1'b1;
                        bus.run_led <= 1'b0;
                    end else if (pause_ev) begin
                        state     <= PAUSED;
                        bus.pause <= 1'b1;
                    end
                end
                PAUSED: begin
                    if (start_ev || pause_ev) begin
                        state     <= RUN;
                        bus.pause <= 1'b0;
                    end
                end
                DONE_ALERT: begin
                    if (start_ev || buzz_cnt <= BUZZ_LAST) begin
                        state      <= IDLE;
                        buzz_cnt   <= '0;
                        bus.buzzer <= 1'b0;
                    end else begin
                        buzz_cnt <= buzz_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_awmc_panel_input.sv
// Vector-table bench for awmc_panel_input with a start-pulse scoreboard.
module tb_awmc_panel_input;

    typedef struct {
        string      name;
        logic       rst;
        logic       s;
        logic       p;
        logic       l;
        logic       d;
        int         hold;
        bit         xs;
        logic [3:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_q[$];
    int   exp_cyc;
    vec_t vecs[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    awmc_panel_input_if bus ();

    awmc_panel_input #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .BUZZ_CYCLES     (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Every observed start pulse must match the next expected cycle.
    always @(negedge clk) begin
        if (bus.start !== 1'b0) begin
            vectors = vectors + 1;
            if (exp_q.size() == 0) begin
                miscompares = miscompares + 1;
                $display("FAIL start_pulse: unexpected pulse at cycle %0d, required none", cyc);
            end else begin
                exp_cyc = exp_q.pop_front();
                if (exp_cyc != cyc) begin
                    miscompares = miscompares + 1;
                    $display("FAIL start_pulse: got at cycle %0d, required cycle %0d", cyc, exp_cyc);
                end
            end
        end
    end

    function automatic vec_t mk(string n, logic r, logic s, logic p, logic l,
                                logic d, int h, bit xs, logic [3:0] e);
        vec_t v;
        v.name = n; v.rst = r; v.s = s; v.p = p; v.l = l; v.d = d;
        v.hold = h; v.xs = xs; v.exp = e;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        logic [3:0] got;
        reset = v.rst;
        bus.btn_start_raw = v.s;
        bus.btn_pause_raw = v.p;
        bus.lid_raw = v.l;
        bus.done = v.d;
        if (v.xs) exp_q.push_back(cyc + 7);
        repeat (v.hold) @(negedge clk);
        got = {bus.pause, bus.lid, bus.buzzer, bus.run_led};
        vectors = vectors + 1;
        if (got !== v.exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: {pause,lid,buzzer,run_led} got %b required %b at cycle %0d",
                     v.name, got, v.exp, cyc);
        end
    endtask

    initial begin
        logic [4:0] rst_out;
        bus.btn_start_raw = 1'b0;
        bus.btn_pause_raw = 1'b0;
        bus.lid_raw = 1'b0;
        bus.done = 1'b0;

        //          name                 rst s  p  l  d  hold xs exp{p,l,b,r}
        vecs.push_back(mk("lid_close",        0, 0, 0, 1, 0, 10, 0, 4'b0100));
        vecs.push_back(mk("start_glitch",     0, 1, 0, 1, 0, 3,  0, 4'b0100));
        vecs.push_back(mk("glitch_settle",    0, 0, 0, 1, 0, 10, 0, 4'b0100));
        vecs.push_back(mk("lid_glitch",       0, 0, 0, 0, 0, 3,  0, 4'b0100));
        vecs.push_back(mk("lid_glitch_settle",0, 0, 0, 1, 0, 10, 0, 4'b0100));
        vecs.push_back(mk("lid_open",         0, 0, 0, 0, 0, 10, 0, 4'b0000));
        vecs.push_back(mk("start_lid_open",   0, 1, 0, 0, 0, 10, 0, 4'b0000));
        vecs.push_back(mk("release_open",     0, 0, 0, 0, 0, 10, 0, 4'b0000));
        vecs.push_back(mk("lid_reclose",      0, 0, 0, 1, 0, 10, 0, 4'b0100));
        vecs.push_back(mk("start_press",      0, 1, 0, 1, 0, 10, 1, 4'b0101));
        vecs.push_back(mk("start_release",    0, 0, 0, 1, 0, 10, 0, 4'b0101));
        vecs.push_back(mk("pause_press",      0, 0, 1, 1, 0, 10, 0, 4'b1101));
        vecs.push_back(mk("pause_release",    0, 0, 0, 1, 0, 10, 0, 4'b1101));
        vecs.push_back(mk("resume_pre",       0, 0, 1, 1, 0, 6,  0, 4'b1101));
        vecs.push_back(mk("resume_edge",      0, 0, 1, 1, 0, 1,  0, 4'b0101));
        vecs.push_back(mk("resume_release",   0, 0, 0, 1, 0, 10, 0, 4'b0101));
        vecs.push_back(mk("done_pulse",       0, 0, 0, 1, 1, 1,  0, 4'b0110));
        vecs.push_back(mk("buzz_hold",        0, 0, 0, 1, 0, 7,  0, 4'b0110));
        vecs.push_back(mk("buzz_end",         0, 0, 0, 1, 0, 1,  0, 4'b0100));
        vecs.push_back(mk("start_press2",     0, 1, 0, 1, 0, 10, 1, 4'b0101));
        vecs.push_back(mk("start_release2",   0, 0, 0, 1, 0, 10, 0, 4'b0101));
        vecs.push_back(mk("start_pre_done",   0, 1, 0, 1, 0, 3,  0, 4'b0101));
        vecs.push_back(mk("done_with_start",  0, 1, 0, 1, 1, 1,  0, 4'b0110));
        vecs.push_back(mk("buzz_mid",         0, 1, 0, 1, 0, 2,  0, 4'b0110));
        vecs.push_back(mk("buzz_cut",         0, 1, 0, 1, 0, 1,  0, 4'b0100));
        vecs.push_back(mk("cut_release",      0, 0, 0, 1, 0, 10, 0, 4'b0100));
        vecs.push_back(mk("start_press3",     0, 1, 0, 1, 0, 10, 1, 4'b0101));
        vecs.push_back(mk("start_release3",   0, 0, 0, 1, 0, 10, 0, 4'b0101));
        vecs.push_back(mk("pause_pre_done",   0, 0, 1, 1, 0, 6,  0, 4'b0101));
        vecs.push_back(mk("pause_and_done",   0, 0, 1, 1, 1, 1,  0, 4'b0110));
        vecs.push_back(mk("alert_pause_ign",  0, 0, 1, 1, 0, 10, 0, 4'b0100));
        vecs.push_back(mk("alert_release",    0, 0, 0, 1, 0, 10, 0, 4'b0100));
        vecs.push_back(mk("start_and_pause",  0, 1, 1, 1, 0, 10, 1, 4'b0101));
        vecs.push_back(mk("both_release",     0, 0, 0, 1, 0, 10, 0, 4'b0101));
        vecs.push_back(mk("pause_press4",     0, 0, 1, 1, 0, 10, 0, 4'b1101));
        vecs.push_back(mk("pause_release4",   0, 0, 0, 1, 0, 10, 0, 4'b1101));
        vecs.push_back(mk("resume_by_start",  0, 1, 0, 1, 0, 10, 0, 4'b0101));
        vecs.push_back(mk("resume_release5",  0, 0, 0, 1, 0, 10, 0, 4'b0101));
        vecs.push_back(mk("pause_press5",     0, 0, 1, 1, 0, 10, 0, 4'b1101));
        vecs.push_back(mk("pause_release5",   0, 0, 0, 1, 0, 10, 0, 4'b1101));
        vecs.push_back(mk("reset_paused",     1, 0, 0, 1, 0, 1,  0, 4'b0000));
        vecs.push_back(mk("post_reset_lid_lo",0, 0, 0, 1, 0, 6,  0, 4'b0000));
        vecs.push_back(mk("post_reset_lid_hi",0, 0, 0, 1, 0, 1,  0, 4'b0100));

        repeat (3) @(negedge clk);
        rst_out = {bus.start, bus.pause, bus.lid, bus.buzzer, bus.run_led};
        vectors = vectors + 1;
        if (rst_out !== 5'b00000) begin
            miscompares = miscompares + 1;
            $display("FAIL reset_state: outputs got %b required 00000", rst_out);
        end

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        repeat (10) @(negedge clk);
        vectors = vectors + 1;
        if (exp_q.size() != 0) begin
            miscompares = miscompares + 1;
            $display("FAIL start_pending: %0d expected pulses never seen, required 0",
                     exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
